// File: rtl/ipv4_rx.sv
// IPv4 receive parser: validates the 20-byte header, checks its checksum and
// forwards only the IP payload (Ethernet padding stripped) with zero latency.
module ipv4_rx #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LEN_W    = 2,
  parameter logic [31:0] IP_ADDR  = 32'hC0A80102,
  parameter logic [7:0]  PROTOCOL = 8'd17
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              ip_cs_err_o,
  output logic              cancel_o
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ST_W  = 4;

  localparam logic [ST_W-1:0] ST_IDLE = 4'b0001;
  localparam logic [ST_W-1:0] ST_HEAD = 4'b0010;
  localparam logic [ST_W-1:0] ST_DATA = 4'b0100;
  localparam logic [ST_W-1:0] ST_DROP = 4'b1000;

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       tot_len_q, tot_len_d;
  logic              rej_q, rej_d, rej_n;
  logic              cs_err_q, cs_err_d;

  logic [16:0]       sum17;
  logic [15:0]       acc_add;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_add;
  logic [CNT_W-1:0]  remain;
  logic [CNT_W-1:0]  len_ext;
  logic [3:0]        word_idx;
  logic              last_beat;
  logic              valid_c, cancel_c;
  logic [LEN_W-1:0]  len_c;

  // One's-complement accumulate with end-around carry; saturating byte count
  assign sum17     = {1'b0, acc_q} + {1'b0, data_i};
  assign acc_add   = sum17[15:0] + 16'(sum17[16]);
  assign cnt_sum   = {1'b0, cnt_q} + (CNT_W+1)'(len_i);
  assign cnt_add   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  assign remain    = tot_len_q - cnt_q;
  assign len_ext   = CNT_W'(len_i);
  assign word_idx  = cnt_q[4:1];
  assign last_beat = (remain == CNT_W'(1)) || (len_ext >= remain);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      tot_len_q <= '0;
      rej_q     <= 1'b0;
      cs_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      tot_len_q <= tot_len_d;
      rej_q     <= rej_d;
      cs_err_q  <= cs_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    tot_len_d = tot_len_q;
    rej_d     = rej_q;
    rej_n     = rej_q;
    cs_err_d  = cs_err_q;
    valid_c   = 1'b0;
    cancel_c  = 1'b0;
    len_c     = len_i;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && !cancel_i) begin
          state_d  = ST_HEAD;
          cnt_d    = CNT_W'(len_i);
          acc_d    = data_i;
          rej_d    = (data_i[15:8] != 8'h45) || (len_i != LEN_W'(2));
          cs_err_d = 1'b0;
        end
      end
      ST_HEAD: begin
        if (cancel_i || !valid_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_add;
          acc_d = acc_add;
          // A short beat inside the header can only be a truncated frame
          rej_n = rej_q || (len_i != LEN_W'(2));
          case (word_idx)
            4'd1: tot_len_d = data_i;
            4'd3: if (data_i[13] || (data_i[12:0] != 13'd0)) rej_n = 1'b1;
            4'd4: if (data_i[7:0] != PROTOCOL) rej_n = 1'b1;
            4'd8: if (data_i != IP_ADDR[31:16]) rej_n = 1'b1;
            4'd9: if (data_i != IP_ADDR[15:0]) rej_n = 1'b1;
            default: ;
          endcase
          rej_d = rej_n;
          if (word_idx == 4'd9) begin
            cs_err_d = (acc_add != 16'hFFFF);
            state_d  = (rej_n || (tot_len_q <= 16'd20)) ? ST_DROP : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cancel_i || !valid_i) begin
          cancel_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          valid_c = 1'b1;
          cnt_d   = cnt_add;
          if (last_beat) begin
            len_c   = (len_ext >= remain) ? LEN_W'(remain) : len_i;
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        cnt_d = cnt_add;
        if (!valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign valid_o     = valid_c & nreset;
  assign cancel_o    = cancel_c & nreset;
  assign ip_cs_err_o = (state_q == ST_DATA) & cs_err_q & nreset;
  assign len_o       = len_c;
  assign data_o      = data_i;

endmodule

// File: tb/tb_ipv4_rx.sv
// Bench for ipv4_rx: directed scenarios plus randomized packets checked
// against a byte-offset model of which frame bytes are IP payload.
module tb_ipv4_rx;

  localparam logic [31:0] IP = 32'hC0A80102;

  logic        clk = 1'b0;
  logic        nreset;
  logic        cancel_i;
  logic        valid_i;
  logic [15:0] data_i;
  logic [1:0]  len_i;
  logic        valid_o;
  logic [15:0] data_o;
  logic [1:0]  len_o;
  logic        ip_cs_err_o;
  logic        cancel_o;

  int checks = 0;
  int fails  = 0;

  ipv4_rx dut (
    .clk         (clk),
    .nreset      (nreset),
    .cancel_i    (cancel_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .len_i       (len_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .len_o       (len_o),
    .ip_cs_err_o (ip_cs_err_o),
    .cancel_o    (cancel_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One inter-frame cycle with valid_i low
  task automatic gap(input string tag, input logic canc, input logic exp_cancel);
    valid_i  = 1'b0;
    cancel_i = canc;
    data_i   = 16'($urandom);
    len_i    = 2'd2;
    #4;
    chk({tag, " gap valid"}, 32'(valid_o), 32'd0);
    chk({tag, " gap cancel"}, 32'(cancel_o), 32'(exp_cancel));
    @(posedge clk); #1;
  endtask

  // Build a frame, drive it and compare every beat against the model
  task automatic send(input string tag, input logic [7:0] w0, input logic [15:0] tl,
                      input int flen, input logic [15:0] frag, input logic [7:0] proto,
                      input logic [31:0] dst, input bit bad_cs, input int cb, input int rst_beat);
    logic [7:0]  fb [128];
    logic [15:0] w [10];
    int          s, nb, o, ln, rem;
    logic [15:0] cs;
    bit          acc, exp_v, exp_c;
    w[0] = {w0, 8'h00}; w[1] = tl; w[2] = 16'($urandom); w[3] = frag;
    w[4] = {8'h40, proto}; w[5] = 16'h0000; w[6] = 16'hC0A8; w[7] = 16'h0101;
    w[8] = dst[31:16]; w[9] = dst[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(w[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
    cs = ~16'(s);
    if (bad_cs) cs = cs + 16'd1;
    w[5] = cs;
    for (int i = 0; i < 10; i++) begin
      fb[2*i] = w[i][15:8]; fb[2*i+1] = w[i][7:0];
    end
    for (int i = 20; i < 128; i++) fb[i] = 8'($urandom);
    acc = (w0 == 8'h45) && !frag[13] && (frag[12:0] == 13'd0) && (proto == 8'd17) &&
          (dst == IP) && (tl > 16'd20);
    nb = (flen + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      o  = 2 * b;
      ln = (o + 2 <= flen) ? 2 : 1;
      valid_i  = 1'b1;
      cancel_i = (b == cb);
      len_i    = 2'(ln);
      data_i   = {fb[o], (ln == 2) ? fb[o+1] : 8'h00};
      if (b == rst_beat) nreset = 1'b0;
      #4;
      if (b == rst_beat) begin
        chk({tag, " rst valid"}, 32'(valid_o), 32'd0);
        chk({tag, " rst cancel"}, 32'(cancel_o), 32'd0);
        chk({tag, " rst cserr"}, 32'(ip_cs_err_o), 32'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        gap(tag, 1'b0, 1'b0);
        return;
      end
      rem   = int'(tl) - o;
      exp_c = (b == cb) && acc && (o >= 20) && (o < int'(tl));
      exp_v = (b != cb) && acc && (o >= 20) && (o < int'(tl));
      chk({tag, " valid"}, 32'(valid_o), 32'(exp_v));
      chk({tag, " cancel"}, 32'(cancel_o), 32'(exp_c));
      if (exp_v) begin
        chk({tag, " len"}, 32'(len_o), 32'((ln < rem) ? ln : rem));
        chk({tag, " data"}, 32'(data_o), 32'(data_i));
        chk({tag, " cserr"}, 32'(ip_cs_err_o), 32'(bad_cs));
      end
      @(posedge clk); #1;
      if (b == cb) break;
    end
    gap(tag, 1'($urandom_range(0, 1)),
        (cb < 0) && acc && (flen >= 20) && (flen < int'(tl)));
    gap(tag, 1'b0, 1'b0);
  endtask

  initial begin
    int kind, tl, flen, cb, nb, frag, proto, w0;
    logic [31:0] dst;
    bit bad;
    nreset = 1'b0; valid_i = 1'b0; cancel_i = 1'b0; data_i = 16'h0; len_i = 2'd2;
    @(posedge clk); @(posedge clk); #1;
    chk("reset valid", 32'(valid_o), 32'd0);
    chk("reset cancel", 32'(cancel_o), 32'd0);
    chk("reset cserr", 32'(ip_cs_err_o), 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;
    gap("post reset", 1'b0, 1'b0);

    send("nominal",  8'h45, 16'd30, 30, 16'h0000, 8'd17, IP, 1'b0, -1, -1);
    send("padding",  8'h45, 16'd29, 60, 16'h0000, 8'd17, IP, 1'b0, -1, -1);
    send("bad dst",  8'h45, 16'd30, 46, 16'h0000, 8'd17, 32'hC0A80103, 1'b0, -1, -1);
    send("bad prot", 8'h45, 16'd30, 46, 16'h0000, 8'd6,  IP, 1'b0, -1, -1);
    send("mf set",   8'h45, 16'd30, 46, 16'h2000, 8'd17, IP, 1'b0, -1, -1);
    send("ihl 6",    8'h46, 16'd30, 46, 16'h0000, 8'd17, IP, 1'b0, -1, -1);
    send("good",     8'h45, 16'd30, 46, 16'h0000, 8'd17, IP, 1'b0, -1, -1);
    send("bad csum", 8'h45, 16'd30, 30, 16'h0000, 8'd17, IP, 1'b1, -1, -1);
    send("cancel3",  8'h45, 16'd30, 30, 16'h0000, 8'd17, IP, 1'b0, 12, -1);
    send("trunc",    8'h45, 16'd30, 24, 16'h0000, 8'd17, IP, 1'b0, -1, -1);
    send("hdr canc", 8'h45, 16'd30, 30, 16'h0000, 8'd17, IP, 1'b0, 4, -1);
    send("tl 20",    8'h45, 16'd20, 46, 16'h0000, 8'd17, IP, 1'b0, -1, -1);
    send("reset",    8'h45, 16'd30, 30, 16'h0000, 8'd17, IP, 1'b0, -1, 11);
    send("after rst",8'h45, 16'd30, 30, 16'h0000, 8'd17, IP, 1'b0, -1, -1);

    for (int p = 0; p < 80; p++) begin
      kind = int'($urandom_range(0, 9));
      w0 = 8'h45; frag = 0; proto = 17; dst = IP; bad = 1'b0;
      case (kind)
        1: dst = IP ^ (32'd1 << $urandom_range(0, 31));
        2: proto = int'($urandom_range(0, 16));
        3: frag = 16'h2000;
        4: frag = int'($urandom_range(1, 8191));
        5: w0 = 8'h46;
        6: bad = 1'b1;
        default: ;
      endcase
      tl   = (kind == 7) ? int'($urandom_range(0, 20)) : int'($urandom_range(21, 80));
      flen = (tl < 20) ? 20 + int'($urandom_range(0, 30)) : tl + int'($urandom_range(0, 10));
      if (flen < 46 && $urandom_range(0, 1) == 1) flen = 46;
      if (tl > 1 && $urandom_range(0, 7) == 0) flen = int'($urandom_range(1, tl - 1));
      nb = (flen + 1) / 2;
      cb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      send("random", 8'(w0), 16'(tl), flen, 16'(frag), 8'(proto), dst, bad, cb, -1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ipv4_rx.md
Name: ipv4_rx

Overview:
- IPv4 receive parser sitting between the Ethernet MAC rx path and udp_rx.
- Consumes the Ethernet payload 16 bits per cycle. Parses and validates the 20-byte IPv4 header, checking version, IHL, fragmentation, protocol and destination address.
- Computes the header checksum and forwards only the IP payload (the UDP datagram), with Ethernet padding stripped.
- Flags checksum failures on `ip_cs_err_o` and aborts in-flight payload on `cancel_o`.

Parameters:
- `DATA_W`, 16, datapath width in bits; only 16 is supported.
- `LEN_W`, 2, byte-count width; `len` is 1 or 2 valid bytes per beat.
- `IP_ADDR`, 32'hC0A80102, local IPv4 address that must match the header destination address.
- `PROTOCOL`, 8'd17, accepted IP protocol number (UDP).

Ports:
- `clk`  in  1  single clock.
- `nreset`  in  1  synchronous reset, active low.
- `cancel_i`  in  1  upstream abort (MAC FCS error or frame abort).
- `valid_i`  in  1  input beat valid; contiguous within a frame; low means end of frame.
- `data_i`  in  16  Ethernet payload; `[15:8]` is the earlier byte on the wire.
- `len_i`  in  2  valid bytes in `data_i`; 1 only on the final beat, in which case `[15:8]` is valid.
- `valid_o`  out  1  IP payload beat valid, toward udp_rx.
- `data_o`  out  16  IP payload, same byte order as `data_i`.
- `len_o`  out  2  valid bytes in `data_o`, 1 or 2.
- `ip_cs_err_o`  out  1  header checksum failed; qualified by `valid_o`.
- `cancel_o`  out  1  abort of the payload currently being forwarded.

Behaviour:
- Reset (`nreset` low at a `clk` edge):
  - State goes to IDLE; byte counter, checksum accumulator and header registers clear.
  - `valid_o`, `ip_cs_err_o` and `cancel_o` are 0 while in reset.
  - A reset in the middle of a packet discards that packet silently.
- Datapath latency is 0: `valid_o`, `data_o`, `len_o` and `cancel_o` are combinational from the current inputs and registered state. `data_o` equals `data_i`.
- States: IDLE, HEAD, DATA, DROP (one-hot). A 16-bit byte counter counts bytes of the current frame.
- IDLE:
  - If `valid_i` is high, this beat is header word 0 (version/IHL, TOS); go to HEAD.
  - A word-0 value other than 8'h45 marks the packet rejected.
- HEAD consumes words 1..9:
  - Capture total_length from word 1.
  - Flags/fragment-offset (word 3): the MF bit or any nonzero offset marks the packet rejected.
  - Protocol is `data_i[7:0]` of word 4.
  - Destination address is words 8..9.
  - On word 9, go to DATA if the packet is accepted. Go to DROP if it is rejected, if total_length < 20, or if total_length == 20.
- Reject conditions: version != 4, IHL != 5, fragmented, protocol != `PROTOCOL`, destination != `IP_ADDR`.
- Checksum:
  - One's-complement sum of words 0..9, including the checksum field, using a 17-bit add with end-around carry.
  - Pass if the final sum is 16'hFFFF.
  - The pass/fail result is registered at the end of HEAD. `ip_cs_err_o` holds the failure flag on every DATA beat; a checksum failure alone does not drop the packet.
- DATA:
  - `valid_o = valid_i & ~cancel_i`.
  - Payload bytes remaining = total_length − byte count.
  - On the beat where the remaining count is 1 or `len_i` ≥ remaining, set `len_o` = min(`len_i`, remaining) and go to DROP if `valid_i` stays high afterward (Ethernet padding), else IDLE.
- DROP: `valid_o` = 0. Stay until `valid_i` is low, then go to IDLE.
- Cancel and truncation:
  - In DATA, `cancel_i` high or `valid_i` low before total_length is reached sets `cancel_o` = 1 for that cycle and forces IDLE.
  - In HEAD, the same events force IDLE with no output.
  - In IDLE or DROP, `cancel_i` forces IDLE or is ignored respectively, and `cancel_o` stays 0.
- Simultaneous events: `cancel_i` takes priority over completing the last beat in the same cycle, so `cancel_o` = 1 and `valid_o` = 0.
- The byte counter saturates rather than wrapping. Frames longer than 65535 bytes are dropped.

Test Plan:
- Nominal: header 4500 001E 0000 0000 4011 csum C0A8 0101 C0A8 0102 with a correct csum, then 10 payload bytes → 5 `valid_o` beats, `len_o` = 2 each, `ip_cs_err_o` = 0, `cancel_o` = 0.
- Padding: the same packet with total_length 0x001D inside a 60-byte frame → 5 beats, last `len_o` = 1, no `valid_o` on pad beats, then IDLE.
- Filtering: destination C0A80103, protocol 0x06, MF = 1, or word 0 = 0x46 (each case separately) → `valid_o` never asserted; next good packet forwarded normally.
- Checksum: corrupt csum by +1 → all payload beats have `valid_o` = 1 with `ip_cs_err_o` = 1.
- Abort: `cancel_i` on the 3rd payload beat → `cancel_o` = 1 and `valid_o` = 0 that cycle; `valid_i` dropped mid-payload → `cancel_o` = 1; `cancel_i` in HEAD → no output.
- Reset: assert `nreset` low during DATA → outputs 0 the next cycle; following packet parsed correctly from word 0.
